ddr2_cmd_arbiter: RTL and testbench

Owns the DDR2 command bus after reset. It passes the power-up sequencer's commands through until initialization completes, then schedules the auto-refresh, write and read sub-blocks onto the single command/address bus. It also runs the tREFI refresh timer and tracks postponed refreshes. It sits between the sub-block sequencers and the PHY output registers.

---
 rtl/ddr2_cmd_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ddr2_cmd_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_cmd_arbiter.sv
// DDR2 command-bus arbiter: passes power-up commands through, then schedules
// auto-refresh, write and read sub-blocks onto one registered command bus.
module ddr2_cmd_arbiter #(
    parameter int REFI_CYC  = 3120,
    parameter int BA_BITS   = 3,
    parameter int ADDR_BITS = 14,
    parameter int MAX_PEND  = 8
) (
    input  logic                 ck_i,
    input  logic                 rst_i,
    input  logic                 init_end_i,
    input  logic                 init_cke_i,
    input  logic [3:0]           init_cmd_i,
    input  logic [BA_BITS-1:0]   init_ba_i,
    input  logic [ADDR_BITS-1:0] init_addr_i,
    output logic                 aref_start_o,
    input  logic                 aref_end_i,
    input  logic [3:0]           aref_cmd_i,
    input  logic [ADDR_BITS-1:0] aref_addr_i,
    input  logic                 wr_req_i,
    output logic                 wr_start_o,
    input  logic                 wr_end_i,
    input  logic [3:0]           wr_cmd_i,
    input  logic [BA_BITS-1:0]   wr_ba_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic                 rd_req_i,
    output logic                 rd_start_o,
    input  logic                 rd_end_i,
    input  logic [3:0]           rd_cmd_i,
    input  logic [BA_BITS-1:0]   rd_ba_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic                 ddr_cke_o,
    output logic [3:0]           ddr_cmd_o,
    output logic [BA_BITS-1:0]   ddr_ba_o,
    output logic [ADDR_BITS-1:0] ddr_addr_o,
    output logic [3:0]           ref_pend_o,
    output logic                 ref_ovf_o
);

    typedef enum logic [2:0] {INIT, IDLE, AREF, WR, RD} state_e;

    localparam logic [3:0] NOP = 4'b0111;
    localparam int TW = (REFI_CYC > 1) ? $clog2(REFI_CYC) : 1;

    state_e                 state_q, state_d;
    logic                   lastWr_q, lastWr_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [3:0]             refPend_q, refPend_d;
    logic                   refOvf_q, refOvf_d;
    logic                   arefStart_q, wrStart_q, rdStart_q;
    logic                   ddrCke_q, ddrCke_d;
    logic [3:0]             ddrCmd_q, ddrCmd_d;
    logic [BA_BITS-1:0]     ddrBa_q, ddrBa_d;
    logic [ADDR_BITS-1:0]   ddrAddr_q, ddrAddr_d;
    logic                   wrap, refDone;

    // Refresh outranks traffic; on a write/read tie the type not served last wins.
    always_comb begin
        state_d  = state_q;
        lastWr_d = lastWr_q;
        case (state_q)
            INIT: if (init_end_i) state_d = IDLE;
            IDLE: begin
                if (refPend_q != 4'd0) begin
                    state_d = AREF;
                end else if (wr_req_i && (!rd_req_i || !lastWr_q)) begin
                    state_d  = WR;
                    lastWr_d = 1'b1;
                end else if (rd_req_i) begin
                    state_d  = RD;
                    lastWr_d = 1'b0;
                end
            end
            AREF:    if (aref_end_i) state_d = IDLE;
            WR:      if (wr_end_i)   state_d = IDLE;
            RD:      if (rd_end_i)   state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        ddrCke_d  = 1'b1;
        ddrCmd_d  = NOP;
        ddrBa_d   = '0;
        ddrAddr_d = '0;
        case (state_q)
            INIT: begin
                ddrCke_d  = init_cke_i;
                ddrCmd_d  = init_cmd_i;
                ddrBa_d   = init_ba_i;
                ddrAddr_d = init_addr_i;
            end
            AREF: begin
                ddrCmd_d  = aref_cmd_i;
                ddrAddr_d = aref_addr_i;
            end
            WR: begin
                ddrCmd_d  = wr_cmd_i;
                ddrBa_d   = wr_ba_i;
                ddrAddr_d = wr_addr_i;
            end
            RD: begin
                ddrCmd_d  = rd_cmd_i;
                ddrBa_d   = rd_ba_i;
                ddrAddr_d = rd_addr_i;
            end
            default: ;
        endcase
    end

    // A wrap coinciding with a completed refresh cancels out, even at saturation.
    always_comb begin
        wrap      = (state_q != INIT) && (timer_q == TW'(REFI_CYC - 1));
        refDone   = (state_q == AREF) && aref_end_i;
        timer_d   = (state_q == INIT || wrap) ? '0 : timer_q + TW'(1);
        refPend_d = refPend_q;
        refOvf_d  = refOvf_q;
        if (state_q == INIT) begin
            refPend_d = 4'd0;
        end else if (wrap && !refDone) begin
            if (refPend_q == 4'(MAX_PEND)) refOvf_d = 1'b1;
            else                           refPend_d = refPend_q + 4'd1;
        end else if (refDone && !wrap && refPend_q != 4'd0) begin
            refPend_d = refPend_q - 4'd1;
        end
    end

    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            lastWr_q    <= 1'b0;
            timer_q     <= '0;
            refPend_q   <= 4'd0;
            refOvf_q    <= 1'b0;
            arefStart_q <= 1'b0;
            wrStart_q   <= 1'b0;
            rdStart_q   <= 1'b0;
            ddrCke_q    <= 1'b0;
            ddrCmd_q    <= NOP;
            ddrBa_q     <= '0;
            ddrAddr_q   <= '0;
        end else begin
            state_q     <= state_d;
            lastWr_q    <= lastWr_d;
            timer_q     <= timer_d;
            refPend_q   <= refPend_d;
            refOvf_q    <= refOvf_d;
            arefStart_q <= (state_q == IDLE) && (state_d == AREF);
            wrStart_q   <= (state_q == IDLE) && (state_d == WR);
            rdStart_q   <= (state_q == IDLE) && (state_d == RD);
            ddrCke_q    <= ddrCke_d;
            ddrCmd_q    <= ddrCmd_d;
            ddrBa_q     <= ddrBa_d;
            ddrAddr_q   <= ddrAddr_d;
        end
    end

    assign aref_start_o = arefStart_q;
    assign wr_start_o   = wrStart_q;
    assign rd_start_o   = rdStart_q;
    assign ddr_cke_o    = ddrCke_q;
    assign ddr_cmd_o    = ddrCmd_q;
    assign ddr_ba_o     = ddrBa_q;
    assign ddr_addr_o   = ddrAddr_q;
    assign ref_pend_o   = refPend_q;
    assign ref_ovf_o    = refOvf_q;

endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// Directed bench for ddr2_cmd_arbiter with a short refresh interval so that
// timer wraps land on hand-computed cycles relative to init exit.
module tb_ddr2_cmd_arbiter;

    localparam int REFI = 100;
    localparam logic [3:0]  NOP       = 4'b0111;
    localparam logic [3:0]  AREF_CMD  = 4'b0001;
    localparam logic [3:0]  WR_CMD    = 4'b0100;
    localparam logic [3:0]  RD_CMD    = 4'b0101;
    localparam logic [2:0]  WR_BA     = 3'd5;
    localparam logic [2:0]  RD_BA     = 3'd2;
    localparam logic [13:0] AREF_ADDR = 14'h1000;
    localparam logic [13:0] WR_ADDR   = 14'h0123;
    localparam logic [13:0] RD_ADDR   = 14'h0456;

    logic        ck = 1'b0;
    logic        rst, initEnd, initCke, arefEnd, wrReq, wrEnd, rdReq, rdEnd;
    logic [3:0]  initCmd;
    logic [2:0]  initBa;
    logic [13:0] initAddr;
    logic        arefStart, wrStart, rdStart, ddrCke, refOvf;
    logic [3:0]  ddrCmd, refPend;
    logic [2:0]  ddrBa;
    logic [13:0] ddrAddr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int kEdge       = 0;

    always #5 ck = ~ck;

    ddr2_cmd_arbiter #(.REFI_CYC(REFI), .BA_BITS(3), .ADDR_BITS(14), .MAX_PEND(8)) dut (
        .ck_i(ck), .rst_i(rst), .init_end_i(initEnd),
        .init_cke_i(initCke), .init_cmd_i(initCmd), .init_ba_i(initBa), .init_addr_i(initAddr),
        .aref_start_o(arefStart), .aref_end_i(arefEnd), .aref_cmd_i(AREF_CMD), .aref_addr_i(AREF_ADDR),
        .wr_req_i(wrReq), .wr_start_o(wrStart), .wr_end_i(wrEnd),
        .wr_cmd_i(WR_CMD), .wr_ba_i(WR_BA), .wr_addr_i(WR_ADDR),
        .rd_req_i(rdReq), .rd_start_o(rdStart), .rd_end_i(rdEnd),
        .rd_cmd_i(RD_CMD), .rd_ba_i(RD_BA), .rd_addr_i(RD_ADDR),
        .ddr_cke_o(ddrCke), .ddr_cmd_o(ddrCmd), .ddr_ba_o(ddrBa), .ddr_addr_o(ddrAddr),
        .ref_pend_o(refPend), .ref_ovf_o(refOvf)
    );

    // Advance n clock edges; outputs are sampled 1 ns after each rising edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
            cyc++;
        end
    endtask

    task automatic runTo(input int target);
        while (cyc < target) applyStimulus(1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; initEnd = 1'b0; initCke = 1'b1; initCmd = 4'b0010; initBa = 3'd0;
        initAddr = 14'h0400; arefEnd = 1'b0; wrReq = 1'b0; wrEnd = 1'b0; rdReq = 1'b0; rdEnd = 1'b0;

        applyStimulus(2);
        checkOutput("rst_cke", ddrCke, 0);
        checkOutput("rst_cmd", ddrCmd, NOP);
        checkOutput("rst_addr", ddrAddr, 0);
        checkOutput("rst_starts", {arefStart, wrStart, rdStart}, 0);
        checkOutput("rst_pend", refPend, 0);
        checkOutput("rst_ovf", refOvf, 0);

        rst = 1'b0;
        applyStimulus(1);
        checkOutput("init_cmd", ddrCmd, 4'b0010);
        checkOutput("init_addr", ddrAddr, 14'h0400);
        checkOutput("init_cke", ddrCke, 1);

        initEnd = 1'b1;
        applyStimulus(1);
        kEdge = cyc;
        initEnd = 1'b0; initCmd = 4'b0000; initCke = 1'b0; initAddr = 14'h0;
        checkOutput("init_last", ddrCmd, 4'b0010);
        applyStimulus(1);
        checkOutput("idle_cmd", ddrCmd, NOP);
        checkOutput("idle_cke", ddrCke, 1);
        checkOutput("idle_addr", ddrAddr, 0);

        runTo(kEdge + 99);
        checkOutput("pre_wrap_pend", refPend, 0);
        runTo(kEdge + 100);
        checkOutput("wrap1_pend", refPend, 1);
        wrReq = 1'b1;
        applyStimulus(1);
        checkOutput("aref_first", {arefStart, wrStart}, 2'b10);
        checkOutput("aref_grant_nop", ddrCmd, NOP);
        applyStimulus(1);
        checkOutput("aref_pulse", arefStart, 0);
        checkOutput("aref_cmd", ddrCmd, AREF_CMD);
        checkOutput("aref_ba", ddrBa, 0);
        checkOutput("aref_addr", ddrAddr, AREF_ADDR);
        arefEnd = 1'b1;
        applyStimulus(1);
        arefEnd = 1'b0;
        checkOutput("aref_dec", refPend, 0);
        checkOutput("wr_not_yet", wrStart, 0);
        applyStimulus(1);
        checkOutput("wr_earliest", wrStart, 1);
        checkOutput("wr_gap_nop", ddrCmd, NOP);
        applyStimulus(1);
        checkOutput("wr_pulse", wrStart, 0);
        checkOutput("wr_cmd", ddrCmd, WR_CMD);
        checkOutput("wr_ba", ddrBa, WR_BA);
        checkOutput("wr_addr", ddrAddr, WR_ADDR);

        rdReq = 1'b1;
        runTo(kEdge + 108);
        wrEnd = 1'b1;
        applyStimulus(1);
        wrEnd = 1'b0;
        checkOutput("rel_idle", rdStart, 0);
        for (int g = 0; g < 4; g++) begin
            int  s;
            logic expWr;
            s = kEdge + 110 + 6 * g;
            expWr = (g % 2) == 1;
            runTo(s);
            checkOutput("alt_start", {wrStart, rdStart}, expWr ? 2'b10 : 2'b01);
            checkOutput("alt_nop", ddrCmd, NOP);
            runTo(s + 1);
            checkOutput("alt_cmd", ddrCmd, expWr ? WR_CMD : RD_CMD);
            checkOutput("alt_ba", ddrBa, expWr ? WR_BA : RD_BA);
            runTo(s + 4);
            if (expWr) wrEnd = 1'b1;
            else       rdEnd = 1'b1;
            applyStimulus(1);
            wrEnd = 1'b0;
            rdEnd = 1'b0;
        end
        rdReq = 1'b0;
        applyStimulus(1);
        checkOutput("single_wr", {wrStart, rdStart}, 2'b10);
        wrReq = 1'b0;

        runTo(kEdge + 499);
        arefEnd = 1'b1;
        applyStimulus(1);
        arefEnd = 1'b0;
        checkOutput("aref_end_ignored", refPend, 4);
        runTo(kEdge + 800);
        checkOutput("pend7", refPend, 7);
        runTo(kEdge + 900);
        checkOutput("pend8", refPend, 8);
        checkOutput("no_ovf_yet", refOvf, 0);
        runTo(kEdge + 1000);
        checkOutput("pend_sat", refPend, 8);
        checkOutput("ovf_set", refOvf, 1);
        checkOutput("wr_held", ddrCmd, WR_CMD);

        runTo(kEdge + 1002);
        wrEnd = 1'b1;
        wrReq = 1'b1;
        applyStimulus(1);
        wrEnd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int a;
            a = kEdge + 1004 + 3 * i;
            runTo(a);
            checkOutput("drain_start", {arefStart, wrStart}, 2'b10);
            runTo(a + 1);
            arefEnd = 1'b1;
            applyStimulus(1);
            arefEnd = 1'b0;
            checkOutput("drain_pend", refPend, 7 - i);
        end
        runTo(kEdge + 1028);
        checkOutput("wr_after_drain", {arefStart, wrStart}, 2'b01);
        checkOutput("ovf_sticky", refOvf, 1);
        wrReq = 1'b0;

        runTo(kEdge + 1200);
        checkOutput("pend2", refPend, 2);
        runTo(kEdge + 1202);
        wrEnd = 1'b1;
        applyStimulus(1);
        wrEnd = 1'b0;
        applyStimulus(1);
        checkOutput("aref_hold_start", arefStart, 1);
        runTo(kEdge + 1299);
        checkOutput("pre_coincide", refPend, 2);
        arefEnd = 1'b1;
        applyStimulus(1);
        arefEnd = 1'b0;
        checkOutput("coincide_pend", refPend, 2);

        wrReq = 1'b1;
        applyStimulus(1);
        checkOutput("aref_again", arefStart, 1);
        runTo(kEdge + 1302);
        arefEnd = 1'b1;
        applyStimulus(1);
        arefEnd = 1'b0;
        checkOutput("pend_after_a", refPend, 1);
        applyStimulus(1);
        checkOutput("aref_last", arefStart, 1);
        runTo(kEdge + 1305);
        arefEnd = 1'b1;
        applyStimulus(1);
        arefEnd = 1'b0;
        applyStimulus(1);
        checkOutput("wr_before_rst", wrStart, 1);

        runTo(kEdge + 1309);
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("mid_rst_cke", ddrCke, 0);
        checkOutput("mid_rst_cmd", ddrCmd, NOP);
        checkOutput("mid_rst_pend", refPend, 0);
        checkOutput("mid_rst_ovf", refOvf, 0);
        checkOutput("mid_rst_starts", {arefStart, wrStart, rdStart}, 0);
        rst = 1'b0;
        applyStimulus(1);
        checkOutput("post_rst_starts", {arefStart, wrStart, rdStart}, 0);
        checkOutput("post_rst_init_cmd", ddrCmd, 4'b0000);
        checkOutput("post_rst_cke", ddrCke, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
